medac_cal_ctrl: RTL and testbench

Calibration sequencer for the metastability-detect-and-correct clock path. On request it sweeps the leading-clock delay code over a programmed range. For each code it runs a timed measurement window on the origin error counter and computes the error delta. It then programs the code with the fewest errors and re-enables correction mode. It sits beside the MEDAC block and drives that block's `start`, `mode` and leading delay select.

---
 rtl/medac_pkg.sv | 21 ++
 rtl/medac_cal_timer.sv | 40 ++++
 rtl/medac_cal_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_medac_cal_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/medac_pkg.sv
// Shared types and default sizing for the MEDAC calibration sequencer.
package medac_pkg;

  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_CODE_W     = 4;
  localparam int unsigned DEF_MEAS_W     = 16;
  localparam int unsigned DEF_SETTLE_CYC = 8;
  localparam int unsigned DEF_DRAIN_CYC  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SNAP   = 3'd3,
    ST_MEAS   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_EVAL   = 3'd6,
    ST_DONE   = 3'd7
  } cal_state_e;

endpackage

// File: rtl/medac_cal_timer.sv
// Loadable down-counter with a registered zero flag; shared by settle, window and drain phases.
module medac_cal_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  // Load wins over decrement; count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/medac_cal_ctrl.sv
// Delay-code calibration sequencer: sweeps the leading delay code, measures error
// deltas per code, programs the best code and re-enables correction mode.
module medac_cal_ctrl
  import medac_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned CODE_W     = DEF_CODE_W,
  parameter int unsigned MEAS_W     = DEF_MEAS_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned DRAIN_CYC  = DEF_DRAIN_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cal_req,
  input  logic              cal_abort,
  input  logic [CODE_W-1:0] code_lo,
  input  logic [CODE_W-1:0] code_hi,
  input  logic [MEAS_W-1:0] meas_cycles,
  input  logic [CNT_W-1:0]  err_thresh,
  input  logic              mode_en,
  input  logic [CNT_W-1:0]  error_origin_cnt,
  output logic              cnt_start,
  output logic              mode,
  output logic [CODE_W-1:0] var_clk_sel_leading,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_fail,
  output logic [CODE_W-1:0] best_code,
  output logic [CNT_W-1:0]  best_err
);

  cal_state_e        state_q, state_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [CODE_W-1:0] hi_q, hi_d;
  logic [CODE_W-1:0] prev_q, prev_d;
  logic [MEAS_W-1:0] meas_q, meas_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic [CNT_W-1:0]  snap0_q, snap0_d;
  logic              rej_q, rej_d;
  logic              cnt_start_q, cnt_start_d;
  logic              mode_q, mode_d;
  logic [CODE_W-1:0] sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [CODE_W-1:0] best_code_q, best_code_d;
  logic [CNT_W-1:0]  best_err_q, best_err_d;

  logic              tmr_load;
  logic [MEAS_W-1:0] tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;
  logic [CNT_W-1:0]  delta;

  medac_cal_timer #(.W(MEAS_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Modular subtraction absorbs counter wrap between snapshot and evaluation.
  assign delta = error_origin_cnt - snap0_q;

  // Next-state and output logic; abort overrides every busy-state transition.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hi_d        = hi_q;
    prev_d      = prev_q;
    meas_d      = meas_q;
    thresh_d    = thresh_q;
    snap0_d     = snap0_q;
    rej_d       = rej_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    best_code_d = best_code_q;
    best_err_d  = best_err_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cal_req) begin
          hi_d       = code_hi;
          meas_d     = meas_cycles;
          thresh_d   = err_thresh;
          prev_d     = sel_q;
          best_err_d = '1;
          fail_d     = 1'b0;
          cur_d      = code_lo;
          rej_d      = (code_lo > code_hi);
          state_d    = (code_lo > code_hi) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        sel_d    = cur_q;
        mode_d   = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = MEAS_W'(SETTLE_CYC - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        snap0_d  = error_origin_cnt;
        tmr_load = 1'b1;
        tmr_val  = (meas_q == '0) ? '0 : meas_q - MEAS_W'(1);
        state_d  = ST_MEAS;
      end
      ST_MEAS: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = MEAS_W'(DRAIN_CYC - 1);
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (delta < best_err_q) begin
          best_err_d  = delta;
          best_code_d = cur_q;
        end
        if (cur_q == hi_q) begin
          state_d = ST_DONE;
        end else begin
          cur_d   = cur_q + CODE_W'(1);
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        if (!rej_q && (best_err_q <= thresh_q)) begin
          sel_d  = best_code_q;
          mode_d = mode_en;
        end else begin
          fail_d = 1'b1;
          sel_d  = prev_q;
          mode_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cal_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      sel_d   = prev_q;
      mode_d  = 1'b0;
      fail_d  = 1'b1;
      done_d  = 1'b1;
    end

    cnt_start_d = (state_d == ST_MEAS);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      prev_q      <= '0;
      meas_q      <= '0;
      thresh_q    <= '0;
      snap0_q     <= '0;
      rej_q       <= 1'b0;
      cnt_start_q <= 1'b0;
      mode_q      <= 1'b0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      best_code_q <= '0;
      best_err_q  <= '1;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      prev_q      <= prev_d;
      meas_q      <= meas_d;
      thresh_q    <= thresh_d;
      snap0_q     <= snap0_d;
      rej_q       <= rej_d;
      cnt_start_q <= cnt_start_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      best_code_q <= best_code_d;
      best_err_q  <= best_err_d;
    end
  end

  assign cnt_start           = cnt_start_q;
  assign mode                = mode_q;
  assign var_clk_sel_leading = sel_q;
  assign cal_busy            = busy_q;
  assign cal_done            = done_q;
  assign cal_fail            = fail_q;
  assign best_code           = best_code_q;
  assign best_err            = best_err_q;

endmodule

// File: tb/tb_medac_cal_ctrl.sv
// Scoreboard bench for medac_cal_ctrl with an error-counter model driven per delay code.
module tb_medac_cal_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cal_req;
  logic        cal_abort;
  logic [3:0]  code_lo;
  logic [3:0]  code_hi;
  logic [15:0] meas_cycles;
  logic [31:0] err_thresh;
  logic        mode_en;
  logic [31:0] error_origin_cnt;
  logic        cnt_start;
  logic        mode;
  logic [3:0]  var_clk_sel_leading;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [3:0]  best_code;
  logic [31:0] best_err;

  medac_cal_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cal_req             (cal_req),
    .cal_abort           (cal_abort),
    .code_lo             (code_lo),
    .code_hi             (code_hi),
    .meas_cycles         (meas_cycles),
    .err_thresh          (err_thresh),
    .mode_en             (mode_en),
    .error_origin_cnt    (error_origin_cnt),
    .cnt_start           (cnt_start),
    .mode                (mode),
    .var_clk_sel_leading (var_clk_sel_leading),
    .cal_busy            (cal_busy),
    .cal_done            (cal_done),
    .cal_fail            (cal_fail),
    .best_code           (best_code),
    .best_err            (best_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Error-counter model: during a window, counts up tbl[code] errors then stops.
  int          tbl [16];
  int          remaining  = 0;
  logic        start_prev = 1'b0;
  int          start_hi   = 0;
  logic [31:0] ecnt_acc   = '0;
  logic [31:0] ecnt_base  = '0;

  assign error_origin_cnt = ecnt_base + ecnt_acc;

  always @(negedge clk) begin
    if (cnt_start) begin
      start_hi <= start_hi + 1;
      if (!start_prev) begin
        if (tbl[var_clk_sel_leading] > 0) begin
          ecnt_acc  <= ecnt_acc + 32'd1;
          remaining <= tbl[var_clk_sel_leading] - 1;
        end else begin
          remaining <= 0;
        end
      end else if (remaining > 0) begin
        ecnt_acc  <= ecnt_acc + 32'd1;
        remaining <= remaining - 1;
      end
    end
    start_prev <= cnt_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    string       name;
    int          req_cyc;
    int          lat;
    logic        fail;
    logic [3:0]  sel;
    logic        mode;
    logic [3:0]  bcode;
    logic [31:0] berr;
  } exp_t;

  exp_t sb[$];

  // Monitor: every cal_done pulse consumes one expected result.
  always @(negedge clk) begin
    if (cal_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.lat != 0) check({e.name, "_latency"}, 32'(cyc - e.req_cyc), 32'(e.lat));
        check({e.name, "_fail"},  32'(cal_fail), 32'(e.fail));
        check({e.name, "_sel"},   32'(var_clk_sel_leading), 32'(e.sel));
        check({e.name, "_mode"},  32'(mode), 32'(e.mode));
        check({e.name, "_bcode"}, 32'(best_code), 32'(e.bcode));
        check({e.name, "_berr"},  best_err, e.berr);
        check({e.name, "_busy"},  32'(cal_busy), 32'd0);
      end
    end
  end

  task automatic push_exp(input string nm, input int rc, input int lat, input logic f,
                          input logic [3:0] s, input logic m, input logic [3:0] bc,
                          input logic [31:0] be);
    exp_t e;
    e.name = nm; e.req_cyc = rc; e.lat = lat; e.fail = f;
    e.sel = s; e.mode = m; e.bcode = bc; e.berr = be;
    sb.push_back(e);
  endtask

  // Issue a one-cycle request at a negedge; returns the cycle stamp of the request.
  task automatic start_cal(input logic [3:0] lo, input logic [3:0] hi, input logic [15:0] mc,
                           input logic [31:0] th, input logic men, output int rc);
    code_lo = lo; code_hi = hi; meas_cycles = mc; err_thresh = th; mode_en = men;
    cal_req = 1'b1;
    rc = cyc;
    @(negedge clk);
    cal_req = 1'b0;
    check("busy_rise", 32'(cal_busy), 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (cal_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_bounded_wait"}, 32'(cal_busy), 32'd0);
    @(negedge clk);
    check({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_sel"},       32'(var_clk_sel_leading), 32'd0);
    check({nm, "_mode"},      32'(mode), 32'd0);
    check({nm, "_cnt_start"}, 32'(cnt_start), 32'd0);
    check({nm, "_busy"},      32'(cal_busy), 32'd0);
    check({nm, "_done"},      32'(cal_done), 32'd0);
    check({nm, "_fail"},      32'(cal_fail), 32'd0);
    check({nm, "_bcode"},     32'(best_code), 32'd0);
    check({nm, "_berr"},      best_err, 32'hFFFF_FFFF);
  endtask

  initial begin
    int rc;
    int hi0;
    int rises;
    int n;
    logic last;

    for (int i = 0; i < 16; i++) tbl[i] = 0;
    rst_n = 1'b0; cal_req = 1'b0; cal_abort = 1'b0;
    code_lo = '0; code_hi = '0; meas_cycles = '0; err_thresh = '0; mode_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // Sweep 2..5: deltas 40,12,12,30 -> tie kept at lower code 3.
    tbl[2] = 40; tbl[3] = 12; tbl[4] = 12; tbl[5] = 30;
    start_cal(4'd2, 4'd5, 16'd100, 32'd50, 1'b1, rc);
    push_exp("sweep", rc, 4 * 115 + 2, 1'b0, 4'd3, 1'b1, 4'd3, 32'd12);
    wait_idle("sweep", 1000);

    // Counter wrap: snapshot 0xFFFF_FFF0, 21 errors -> end value 0x5.
    ecnt_base = 32'hFFFF_FFF0 - ecnt_acc;
    tbl[6] = 21;
    start_cal(4'd6, 4'd6, 16'd100, 32'd50, 1'b0, rc);
    push_exp("wrap", rc, 115 + 2, 1'b0, 4'd6, 1'b0, 4'd6, 32'd21);
    wait_idle("wrap", 400);
    check("wrap_cnt_end", error_origin_cnt, 32'h0000_0005);

    // Threshold fail: all deltas above threshold, previous code 6 restored.
    tbl[0] = 60; tbl[1] = 70; tbl[2] = 65;
    start_cal(4'd0, 4'd2, 16'd100, 32'd50, 1'b1, rc);
    push_exp("thresh", rc, 3 * 115 + 2, 1'b1, 4'd6, 1'b0, 4'd0, 32'd60);
    wait_idle("thresh", 800);

    // Rejected range: done two cycles after request, no window opened.
    hi0 = start_hi;
    start_cal(4'd7, 4'd3, 16'd100, 32'hFFFF_FFFF, 1'b1, rc);
    push_exp("reject", rc, 2, 1'b1, 4'd6, 1'b0, 4'd0, 32'hFFFF_FFFF);
    wait_idle("reject", 10);
    check("reject_no_cnt_start", 32'(start_hi - hi0), 32'd0);

    // Abort during the second code's window; a mid-sweep request is ignored.
    tbl[1] = 10; tbl[2] = 10; tbl[3] = 10;
    start_cal(4'd1, 4'd3, 16'd100, 32'd50, 1'b1, rc);
    code_lo = 4'd9; code_hi = 4'd9; cal_req = 1'b1;
    @(negedge clk);
    cal_req = 1'b0;
    check("busy_req_ignored_busy", 32'(cal_busy), 32'd1);
    rises = 0; n = 0; last = cnt_start;
    while (rises < 2 && n < 1000) begin
      @(negedge clk);
      if (cnt_start && !last) rises++;
      last = cnt_start;
      n++;
    end
    check("abort_reach_meas2", 32'(rises), 32'd2);
    repeat (10) @(negedge clk);
    check("abort_meas2_sel", 32'(var_clk_sel_leading), 32'd2);
    check("abort_meas2_cnt_start", 32'(cnt_start), 32'd1);
    push_exp("abort", rc, 0, 1'b1, 4'd6, 1'b0, 4'd1, 32'd10);
    cal_abort = 1'b1;
    @(negedge clk);
    cal_abort = 1'b0;
    check("abort_cnt_start_low", 32'(cnt_start), 32'd0);
    check("abort_sel_restored", 32'(var_clk_sel_leading), 32'd6);
    check("abort_fail", 32'(cal_fail), 32'd1);
    @(negedge clk);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);

    // Zero-length window behaves as one cycle.
    tbl[4] = 0;
    hi0 = start_hi;
    start_cal(4'd4, 4'd4, 16'd0, 32'd50, 1'b1, rc);
    push_exp("meas0", rc, 8 + 1 + 4 + 3 + 2, 1'b0, 4'd4, 1'b1, 4'd4, 32'd0);
    wait_idle("meas0", 100);
    check("meas0_cnt_start_cycles", 32'(start_hi - hi0), 32'd1);

    // Asynchronous reset in the middle of SETTLE.
    start_cal(4'd5, 4'd5, 16'd100, 32'd50, 1'b1, rc);
    @(negedge clk);
    check("settle_sel", 32'(var_clk_sel_leading), 32'd5);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("after_async_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
